// File: rtl/sram_pkg.sv
// Shared types and constants for the external SRAM controller.
// Optional read buffer is enabled by defining SRAM_READ_BUF_EN.
// Holds the FSM state encoding, half-word selectors and default data base.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic        HALF_LO           = 1'b0;
  localparam logic        HALF_HI           = 1'b1;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int          WAIT_W            = 3;

endpackage

// File: rtl/sram_wait_cnt.sv
// Wait-state down-counter: reloads to WAIT_CYCLES, counts to zero, then holds.
// Latency: o_last is high in the final cycle of each half-word access.
// Backpressure: none; the controller reloads it on every LOW/HIGH entry.
module sram_wait_cnt
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_last,
  output logic o_penult
);

  localparam logic [WAIT_W-1:0] LOAD_VAL = WAIT_W'(WAIT_CYCLES);

  logic [WAIT_W-1:0] r_cnt;

  // Reload on phase entry, otherwise count down and stick at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last   = (r_cnt == '0);
  assign o_penult = (r_cnt == WAIT_W'(1));

endmodule

// File: rtl/sram_mem_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two wait-stated 16-bit SRAM accesses.
// Latency: ready rises 2*(WAIT_CYCLES+1)+1 cycles after the request (1 on a read-buffer hit).
// Backpressure: ready stays low for the whole access; SRAM_READ_BUF_EN adds a one-entry read buffer.
module sram_mem_ctrl
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_mem_r_en,
  input  logic               i_mem_w_en,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_ready,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic               o_sram_we_n,
  output logic [15:0]        o_sram_dq_o,
  output logic               o_sram_dq_oe,
  input  logic [15:0]        i_sram_dq_i
);

  localparam int   IW         = SRAM_AW - 1;
  localparam logic HAS_STROBE = (WAIT_CYCLES != 0);

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_wr;
  logic [15:0]     r_lo;

  logic [31:0]     w_off;
  logic [IW-1:0]   w_idx;
  logic            w_req;
  logic            w_hit;
  logic [31:0]     w_buf_dat;
  logic            w_load;
  logic            w_last;
  logic            w_penult;
  logic            w_unused_off;

  // Word index wraps modulo the SRAM; the byte offset within a word is ignored.
  assign w_off        = i_addr - BASE_ADDR;
  assign w_idx        = w_off[IW+1:2];
  assign w_unused_off = ^{w_off[31:IW+2], w_off[1:0]};
  assign w_req        = i_mem_r_en | i_mem_w_en;

  // The counter restarts whenever a half-word phase begins.
  assign w_load = ((r_state == IDLE) && w_req && !w_hit) ||
                  ((r_state == LOW) && w_last);

  sram_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .o_last   (w_last),
    .o_penult (w_penult)
  );

`ifdef SRAM_READ_BUF_EN
  logic          r_buf_vld;
  logic [IW-1:0] r_buf_tag;
  logic [31:0]   r_buf_dat;

  assign w_hit     = i_mem_r_en && !i_mem_w_en && r_buf_vld && (r_buf_tag == w_idx);
  assign w_buf_dat = r_buf_dat;

  // Buffer tracks the last completed load; stores to the same word keep it coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_vld <= 1'b0;
      r_buf_tag <= '0;
      r_buf_dat <= '0;
    end else if ((r_state == IDLE) && i_mem_w_en) begin
      if (r_buf_vld && (r_buf_tag == w_idx)) begin
        r_buf_dat <= i_wdata;
      end
    end else if ((r_state == HIGH) && w_last && !r_wr) begin
      r_buf_vld <= 1'b1;
      r_buf_tag <= r_idx;
      r_buf_dat <= {i_sram_dq_i, r_lo};
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_buf_dat = '0;
`endif

  // IDLE lets the pipeline run unless a request is pending; DONE releases it for one cycle.
  assign o_ready = (r_state == IDLE) ? ~w_req : (r_state == DONE);

  // Access sequencer with registered pad controls; the strobe drops one cycle before each phase ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_wr         <= 1'b0;
      r_lo         <= '0;
      o_rdata      <= '0;
      o_sram_addr  <= '0;
      o_sram_we_n  <= 1'b1;
      o_sram_dq_o  <= '0;
      o_sram_dq_oe <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx   <= w_idx;
            r_wdata <= i_wdata;
            r_wr    <= i_mem_w_en;
            if (w_hit) begin
              r_state <= DONE;
              o_rdata <= w_buf_dat;
            end else begin
              r_state      <= LOW;
              o_sram_addr  <= {w_idx, HALF_LO};
              o_sram_dq_o  <= i_wdata[15:0];
              o_sram_dq_oe <= i_mem_w_en;
              o_sram_we_n  <= ~(i_mem_w_en & HAS_STROBE);
            end
          end
        end
        LOW: begin
          if (w_last) begin
            if (!r_wr) begin
              r_lo <= i_sram_dq_i;
            end
            r_state     <= HIGH;
            o_sram_addr <= {r_idx, HALF_HI};
            o_sram_dq_o <= r_wdata[31:16];
            o_sram_we_n <= ~(r_wr & HAS_STROBE);
          end else begin
            o_sram_we_n <= ~(r_wr & ~w_penult);
          end
        end
        HIGH: begin
          if (w_last) begin
            if (!r_wr) begin
              o_rdata <= {i_sram_dq_i, r_lo};
            end
            r_state      <= DONE;
            o_sram_we_n  <= 1'b1;
            o_sram_dq_oe <= 1'b0;
          end else begin
            o_sram_we_n <= ~(r_wr & ~w_penult);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
